lh_sync_sequencer: RTL and testbench

- Sequences one Lighthouse capture cycle: detects the sync pulse from station A, then from station B, classifies each by pulse width into a 3-bit code, picks the sweeping station, and opens the sweep window.
- In the sweep window, time-stamps the centre of each sensor's first hit.
- Presents each completed cycle to the SPI readout / packing logic over a valid/ready handshake.
- Sits between the LH_SENSOR pins and the readout path.
- Timing reference is CLK at 48 MHz, so 1 tick = 20.833 ns.

---
 rtl/lh_sync_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_lh_sync_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lh_sync_sequencer.sv
// rtl/lh_sync_sequencer.sv - Lighthouse capture cycle sequencer: sync decode, sweep hit centres, valid/ready result
module lh_sync_sequencer #(
    parameter int NUM_SENSORS = 5,
    parameter int TIMER_WIDTH = 20,
    parameter int SYNC_MIN    = 2000,
    parameter int SYNC_MAX    = 6720,
    parameter int SYNC_BASE   = 2750,
    parameter int SYNC_STEP   = 500,
    parameter int GAP_MAX     = 24000,
    parameter int SWEEP_END   = 384000
) (
    input  logic                               CLK,
    input  logic                               RESET_N,
    input  logic [NUM_SENSORS-1:0]             LH_SENSOR,
    output logic                               CYCLE_VALID,
    input  logic                               CYCLE_READY,
    output logic                               STATION,
    output logic                               AXIS,
    output logic [2:0]                         A_CODE,
    output logic [2:0]                         B_CODE,
    output logic                               B_SEEN,
    output logic [NUM_SENSORS-1:0]             HIT_MASK,
    output logic [NUM_SENSORS*TIMER_WIDTH-1:0] HIT_TIME,
    output logic                               OVERRUN,
    output logic                               SYNC_ERR
);
    localparam int CW = 13;
    localparam int SW = (SYNC_STEP > 1) ? $clog2(SYNC_STEP) : 1;
    localparam int TW = TIMER_WIDTH;
    localparam int NS = NUM_SENSORS;

    typedef enum logic [2:0] {IDLE, SYNC_A, WAIT_B, SYNC_B, SWEEP, PUBLISH} state_t;
    state_t state, state_next;

    logic [NS-1:0]    sync1, sync2, low, low_d;
    logic             any_low, any_low_d, pulse_start, pulse_end;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    step_cnt;
    logic [2:0]       code_cnt;
    logic [TW-1:0]    timer;
    logic [2:0]       a_code, b_code;
    logic             b_seen, station;
    logic [NS-1:0]    armed, hit;
    logic [NS*TW-1:0] fall_time, hit_time, centre;
    logic             short_pulse, long_pulse, sweep_long, a_start, transfer, publish_load;
    logic             err, latch_a, latch_b;

    assign low         = ~sync2;
    assign any_low     = |low;
    assign pulse_start = any_low & ~any_low_d;
    assign pulse_end   = ~any_low & any_low_d;
    // cnt still holds the previous width during the start cycle, so it is excluded there
    assign short_pulse = cnt < CW'(SYNC_MIN);
    assign long_pulse  = any_low && !pulse_start && (cnt == CW'(SYNC_MAX));
    assign sweep_long  = any_low && !pulse_start && (cnt >= CW'(SYNC_MIN));
    assign a_start     = (state == IDLE) && pulse_start;
    assign transfer    = CYCLE_VALID & CYCLE_READY;
    assign publish_load = (state == PUBLISH) && (!CYCLE_VALID || transfer);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1     <= '1;
            sync2     <= '1;
            low_d     <= '0;
            any_low_d <= 1'b0;
            cnt       <= '0;
            step_cnt  <= '0;
            code_cnt  <= '0;
            timer     <= '0;
        end else begin
            sync1     <= LH_SENSOR;
            sync2     <= sync1;
            low_d     <= low;
            any_low_d <= any_low;
            if (pulse_start) begin
                cnt      <= '0;
                step_cnt <= '0;
                code_cnt <= '0;
            end else if (any_low && cnt != '1) begin
                cnt <= cnt + 1'b1;
                // code = floor((w - base) / step), accumulated one tick at a time
                if (cnt >= CW'(SYNC_BASE)) begin
                    if (step_cnt == SW'(SYNC_STEP - 1)) begin
                        step_cnt <= '0;
                        if (code_cnt != 3'd7) code_cnt <= code_cnt + 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
            end
            if (a_start)          timer <= '0;
            else if (timer != '1) timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        err        = 1'b0;
        latch_a    = 1'b0;
        latch_b    = 1'b0;
        case (state)
            IDLE:    if (pulse_start) state_next = SYNC_A;
            SYNC_A: begin
                if (long_pulse) begin
                    err = 1'b1;
                    state_next = IDLE;
                end else if (pulse_end) begin
                    if (short_pulse) state_next = IDLE;
                    else begin
                        latch_a    = 1'b1;
                        state_next = WAIT_B;
                    end
                end
            end
            WAIT_B: begin
                if (pulse_start) state_next = SYNC_B;
                else if (timer >= TW'(GAP_MAX)) begin
                    if (!a_code[2]) state_next = SWEEP;
                    else begin
                        err = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            SYNC_B: begin
                if (long_pulse) begin
                    err = 1'b1;
                    state_next = IDLE;
                end else if (pulse_end) begin
                    if (short_pulse) state_next = WAIT_B;
                    else begin
                        latch_b = 1'b1;
                        if (a_code[2] != code_cnt[2]) state_next = SWEEP;
                        else begin
                            err = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            SWEEP: begin
                if (sweep_long) begin
                    err = 1'b1;
                    state_next = IDLE;
                end else if (timer >= TW'(SWEEP_END)) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        centre = '0;
        for (int i = 0; i < NS; i++)
            centre[i*TW +: TW] = TW'(({1'b0, fall_time[i*TW +: TW]} + {1'b0, timer}) >> 1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_code <= '0; b_code <= '0; b_seen <= 1'b0; station <= 1'b0;
            armed <= '0; hit <= '0; fall_time <= '0; hit_time <= '0;
        end else if (a_start) begin
            a_code <= '0; b_code <= '0; b_seen <= 1'b0; station <= 1'b0;
            armed <= '0; hit <= '0; fall_time <= '0; hit_time <= '0;
        end else begin
            if (latch_a) a_code <= code_cnt;
            if (latch_b) begin
                b_code  <= code_cnt;
                b_seen  <= 1'b1;
                station <= a_code[2];
            end
            if (state == SWEEP) begin
                for (int i = 0; i < NS; i++) begin
                    if (!hit[i]) begin
                        if (low[i] && !low_d[i] && !armed[i]) begin
                            fall_time[i*TW +: TW] <= timer;
                            armed[i] <= 1'b1;
                        end else if (!low[i] && low_d[i] && armed[i]) begin
                            hit_time[i*TW +: TW] <= centre[i*TW +: TW];
                            hit[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CYCLE_VALID <= 1'b0; STATION <= 1'b0; AXIS <= 1'b0;
            A_CODE <= '0; B_CODE <= '0; B_SEEN <= 1'b0;
            HIT_MASK <= '0; HIT_TIME <= '0; OVERRUN <= 1'b0; SYNC_ERR <= 1'b0;
        end else begin
            SYNC_ERR <= err;
            if (publish_load) begin
                CYCLE_VALID <= 1'b1;
                STATION     <= station;
                AXIS        <= station ? b_code[0] : a_code[0];
                A_CODE      <= a_code;
                B_CODE      <= b_code;
                B_SEEN      <= b_seen;
                HIT_MASK    <= hit;
                HIT_TIME    <= hit_time;
            end else if (transfer) begin
                CYCLE_VALID <= 1'b0;
            end
            if (transfer)                               OVERRUN <= 1'b0;
            else if (state == PUBLISH && CYCLE_VALID)   OVERRUN <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lh_sync_sequencer.sv
// tb/tb_lh_sync_sequencer.sv - table-driven bench for lh_sync_sequencer with scaled timing parameters
module tb_lh_sync_sequencer;
    localparam int NS = 5;
    localparam int TW = 20;
    localparam int SMIN = 100, SMAX = 336, SBASE = 137, SSTEP = 25, GAP = 1200, SEND = 4000;
    localparam int CYC = 4150;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic [NS-1:0]   LH_SENSOR = '1;
    logic            CYCLE_READY = 1'b0;
    logic            CYCLE_VALID, STATION, AXIS, B_SEEN, OVERRUN, SYNC_ERR;
    logic [2:0]      A_CODE, B_CODE;
    logic [NS-1:0]   HIT_MASK;
    logic [NS*TW-1:0] HIT_TIME;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_t = -1;
    int e0;

    lh_sync_sequencer #(
        .NUM_SENSORS(NS), .TIMER_WIDTH(TW), .SYNC_MIN(SMIN), .SYNC_MAX(SMAX),
        .SYNC_BASE(SBASE), .SYNC_STEP(SSTEP), .GAP_MAX(GAP), .SWEEP_END(SEND)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .LH_SENSOR(LH_SENSOR),
        .CYCLE_VALID(CYCLE_VALID), .CYCLE_READY(CYCLE_READY),
        .STATION(STATION), .AXIS(AXIS), .A_CODE(A_CODE), .B_CODE(B_CODE),
        .B_SEEN(B_SEEN), .HIT_MASK(HIT_MASK), .HIT_TIME(HIT_TIME),
        .OVERRUN(OVERRUN), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int       a_w;
        int       b_w;
        int       hits;
        bit       valid;
        bit       station;
        bit       axis;
        bit [2:0] a_code;
        bit [2:0] b_code;
        bit       b_seen;
        int       errs;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +-%0d", name, act, exp, tol);
        end
    endtask

    // Sensor levels at tick t: A at 0, B at 400, hits at 2000+40*i for 10 ticks
    function automatic logic [NS-1:0] lh_at(input int t, input int a_w, input int b_w,
                                            input int hits, input int extra);
        logic [NS-1:0] l;
        l = '0;
        if (t < a_w) l = '1;
        if (b_w > 0 && t >= 400 && t < 400 + b_w) l = '1;
        if (extra == 3 && t >= 300 && t < 330) l = '1;
        for (int i = 0; i < hits; i++)
            if (t >= 2000 + 40*i && t < 2010 + 40*i) l[i] = 1'b1;
        if (extra == 1) begin
            if (t >= 2300 && t < 2310) l[0] = 1'b1;
            if (t >= 3950) l[4] = 1'b1;
        end
        if (extra == 2 && t >= 2500 && t < 2650) l[2] = 1'b1;
        return ~l;
    endfunction

    task automatic run_cycle(input int a_w, input int b_w, input int hits, input int extra,
                             input int ready_at, input int len);
        err_t = -1;
        for (int t = 0; t < len; t++) begin
            @(negedge CLK);
            if (SYNC_ERR) begin
                err_seen++;
                if (err_t < 0) err_t = t;
            end
            LH_SENSOR   = lh_at(t, a_w, b_w, hits, extra);
            CYCLE_READY = (t == ready_at);
        end
        @(negedge CLK);
        if (SYNC_ERR) err_seen++;
        LH_SENSOR   = '1;
        CYCLE_READY = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic st, input logic ax,
                             input logic [2:0] ac, input logic [2:0] bc, input logic bs,
                             input int hits);
        logic [NS-1:0] m;
        m = NS'((1 << hits) - 1);
        chk({tag, "_valid"}, CYCLE_VALID, 1);
        chk({tag, "_station"}, STATION, st);
        chk({tag, "_axis"}, AXIS, ax);
        chk({tag, "_acode"}, A_CODE, ac);
        chk({tag, "_bcode"}, B_CODE, bc);
        chk({tag, "_bseen"}, B_SEEN, bs);
        chk({tag, "_mask"}, HIT_MASK, m);
        for (int i = 0; i < NS; i++) begin
            if (i < hits) chk_near($sformatf("%s_time%0d", tag, i), int'(HIT_TIME[i*TW +: TW]), 2004 + 40*i, 2);
            else          chk($sformatf("%s_time%0d", tag, i), HIT_TIME[i*TW +: TW], 0);
        end
    endtask

    task automatic consume(input string tag);
        @(negedge CLK);
        CYCLE_READY = 1'b1;
        @(negedge CLK);
        CYCLE_READY = 1'b0;
        chk({tag, "_valid_after_xfer"}, CYCLE_VALID, 0);
        chk({tag, "_overrun_after_xfer"}, OVERRUN, 0);
    endtask

    initial begin
        //          a_w  b_w  hits valid st ax  acode bcode seen errs
        vecs[0] = '{200, 275, 1,   1'b1, 0, 0, 3'd2, 3'd5, 1'b1, 0};
        vecs[1] = '{275, 225, 5,   1'b1, 1, 1, 3'd5, 3'd3, 1'b1, 0};
        vecs[2] = '{150, 170, 0,   1'b0, 0, 0, 3'd0, 3'd0, 1'b0, 1};
        vecs[3] = '{250, 0,   0,   1'b0, 0, 0, 3'd0, 3'd0, 1'b0, 1};
        vecs[4] = '{225, 0,   2,   1'b1, 0, 1, 3'd3, 3'd0, 1'b0, 0};
        vecs[5] = '{120, 330, 3,   1'b1, 0, 0, 3'd0, 3'd7, 1'b1, 0};
        vecs[6] = '{330, 275, 0,   1'b0, 0, 0, 3'd0, 3'd0, 1'b0, 1};

        repeat (3) @(negedge CLK);
        chk("reset_outputs", {CYCLE_VALID, STATION, AXIS, A_CODE, B_CODE, B_SEEN, HIT_MASK, OVERRUN, SYNC_ERR}, 0);
        chk("reset_hit_time", HIT_TIME[63:0], 0);
        RESET_N = 1'b1;
        e0 = err_seen;
        run_cycle(0, 0, 0, 0, -1, 2000);
        chk("idle_no_err", err_seen - e0, 0);
        chk("idle_no_valid", CYCLE_VALID, 0);

        e0 = err_seen;
        run_cycle(48, 0, 0, 0, -1, CYC);
        chk("glitch_no_err", err_seen - e0, 0);
        chk("glitch_no_valid", CYCLE_VALID, 0);

        e0 = err_seen;
        run_cycle(400, 0, 0, 0, -1, 1500);
        chk("long_err_count", err_seen - e0, 1);
        chk_near("long_err_tick", err_t, SMAX + 4, 2);
        chk("long_no_valid", CYCLE_VALID, 0);

        for (int k = 0; k < 7; k++) begin
            e0 = err_seen;
            run_cycle(vecs[k].a_w, vecs[k].b_w, vecs[k].hits, 0, -1, CYC);
            chk($sformatf("v%0d_errs", k), err_seen - e0, vecs[k].errs);
            if (vecs[k].valid) begin
                check_out($sformatf("v%0d", k), vecs[k].station, vecs[k].axis, vecs[k].a_code,
                          vecs[k].b_code, vecs[k].b_seen, vecs[k].hits);
                consume($sformatf("v%0d", k));
            end else begin
                chk($sformatf("v%0d_no_valid", k), CYCLE_VALID, 0);
            end
        end

        e0 = err_seen;
        run_cycle(200, 275, 4, 1, -1, CYC);
        chk("rehit_errs", err_seen - e0, 0);
        check_out("rehit", 0, 0, 3'd2, 3'd5, 1, 4);
        consume("rehit");

        e0 = err_seen;
        run_cycle(200, 275, 0, 2, -1, CYC);
        chk("sweep_long_errs", err_seen - e0, 1);
        chk("sweep_long_no_valid", CYCLE_VALID, 0);

        run_cycle(200, 275, 1, 0, -1, CYC);
        run_cycle(275, 225, 5, 0, -1, CYC);
        check_out("hold", 0, 0, 3'd2, 3'd5, 1, 1);
        chk("hold_overrun", OVERRUN, 1);
        consume("hold");

        run_cycle(200, 275, 1, 0, -1, CYC);
        run_cycle(275, 225, 5, 3, 4004, CYC);
        check_out("simul", 1, 1, 3'd5, 3'd3, 1, 5);
        chk("simul_overrun", OVERRUN, 0);

        run_cycle(200, 275, 1, 0, -1, 3000);
        RESET_N = 1'b0;
        #1;
        chk("midreset_outputs", {CYCLE_VALID, STATION, AXIS, A_CODE, B_CODE, B_SEEN, HIT_MASK, OVERRUN}, 0);
        chk("midreset_hit_time", HIT_TIME[63:0], 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        e0 = err_seen;
        run_cycle(200, 275, 1, 0, -1, CYC);
        chk("after_reset_errs", err_seen - e0, 0);
        check_out("after_reset", 0, 0, 3'd2, 3'd5, 1, 1);
        consume("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
